// File: rtl/uart_pkg.sv
// Shared types and constants for the board UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int BAUD_DIV_115200 = 434;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous single-bit inputs (UART_RXD, SW, KEY).
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= {STAGES{RESET_VAL}};
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, one-deep output register, framing/overrun pulses.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_DIV_115200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  uart_rx_state_t state, state_next;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           rxs, rxs_d;
  logic           cnt_clr, shift_en, deliver, ferr;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
    .clk   (CLOCK_50),
    .reset (reset),
    .d     (UART_RXD),
    .q     (rxs)
  );

  // START ends at the half point, so every later sample lands mid-bit
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    ferr       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rxs_d && !rxs) state_next = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_clr    = 1'b1;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr       = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      rxs_d     <= 1'b1;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      rxs_d     <= rxs;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      frame_err <= ferr;
      overrun   <= deliver && rx_valid && !rx_ack;
      if (state != DATA)  bit_idx <= 3'd0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg[bit_idx] <= rxs;
      // An unacknowledged byte wins over a newly completed one
      if (deliver) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
